reg_file_mp: RTL
================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DataWidth, default 64, SHALL set the register and data-bus width in bits.
REQ-002 Parameter NumRegs, default 32, SHALL set the register count (power of two, at least 4).
REQ-003 Parameter NumReadPorts, default 3, SHALL set the number of independent read ports (1..4).
REQ-004 Parameter IndexWidth, default $clog2(NumRegs), SHALL set the address width.
REQ-005 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-006 Port rst, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-007 Ports writeEn, input, 2 bits, SHALL hold the per-write-port enables (port 0 and port 1).
REQ-008 Ports writeAddr, input, 2 x IndexWidth, SHALL hold the per-write-port addresses.
REQ-009 Ports writeData, input, 2 x DataWidth, SHALL hold the per-write-port data.
REQ-010 Ports readAddr, input, NumReadPorts x IndexWidth, SHALL hold the per-read-port addresses.
REQ-011 Ports readData, output, NumReadPorts x DataWidth, SHALL hold the per-read-port data.
REQ-012 Ports readBusy, output, NumReadPorts x 1, SHALL hold the scoreboard busy bit of each read address.
REQ-013 Ports rsvEn/rsvAddr, input, 1 bit / IndexWidth, SHALL mark a register busy (pending result).
REQ-014 Port clrStart, input, 1 bit, SHALL request a sequential clear of the whole file.
REQ-015 Port clrBusy, output, 1 bit, SHALL be high while a clear sequence runs.

Function
REQ-016 Register 0 SHALL always read 0; writes and reservations to address 0 SHALL be ignored.
REQ-017 An enabled write SHALL update its register at the next rising clk edge (one-cycle write latency).
REQ-018 If both write ports target the same non-zero address in one cycle, port 1 SHALL win.
REQ-019 Reads SHALL be combinational from register contents, subject to REQ-033.
REQ-020 rsvEn SHALL set busy[rsvAddr] at the next edge.
REQ-021 Any committed write SHALL clear busy[writeAddr] at the next edge.
REQ-022 If a reservation and a write hit the same address in one cycle, the reservation SHALL win (busy=1, data written).
REQ-023 The clear FSM SHALL have two states, IDLE and CLEAR.
REQ-024 IDLE->CLEAR SHALL occur on clrStart; the clear counter SHALL load 1.
REQ-025 In CLEAR, one register per cycle SHALL be zeroed and its busy bit cleared; the counter SHALL increment.
REQ-026 CLEAR->IDLE SHALL occur after register NumRegs-1 is cleared, so a clear lasts NumRegs-1 cycles.
REQ-027 clrBusy SHALL equal (state==CLEAR).
REQ-028 While clrBusy is high, writeEn, rsvEn and clrStart SHALL be ignored.
REQ-029 While clrBusy is high, reads SHALL remain valid; already-cleared registers SHALL return 0.

Reset
REQ-030 rst SHALL asynchronously zero all registers and busy bits and force the FSM to IDLE with the counter at 0.
REQ-031 After reset, readData SHALL be 0, readBusy 0 and clrBusy 0.
REQ-032 rst asserted mid-clear SHALL abort the clear; no further clear cycles SHALL follow reset release.

Configuration
REQ-033 With macro REG_FILE_BYPASS_EN defined, a read whose address matches an enabled same-cycle write (non-zero, not during clear) SHALL return that write data, with port 1 priority; without it, reads SHALL return pre-edge contents.
REQ-034 With REG_FILE_BYPASS_EN defined, readBusy SHALL read 0 for an address being written in that cycle unless it is also being reserved.

Structure
REQ-035 Package reg_file_pkg SHALL hold the clear-FSM state enum and the write-port count constant (2).
REQ-036 The busy-bit scoreboard SHALL be sub-module reg_scoreboard (set/clear ports, NumRegs-bit vector).

Verification
REQ-037 Reset, then read all ports at addresses 1..31 -> all readData 0, readBusy 0, clrBusy 0.
REQ-038 Write port 0 at address 5 with 0xAAAA and port 1 at address 5 with 0x5555 in one cycle -> next cycle address 5 reads 0x5555; address 0 write of 0xFFFF -> still reads 0.
REQ-039 Reserve address 7, then write address 7 with 0x1234 two cycles later -> readBusy 1 for two cycles, then 0; data reads 0x1234.
REQ-040 Same-cycle write address 3 with 0xBEEF while reading address 3 -> 0xBEEF if REG_FILE_BYPASS_EN is defined, old value otherwise.
REQ-041 Fill addresses 1..31, pulse clrStart -> clrBusy high for 31 cycles, writes ignored, then all registers read 0.
REQ-042 Assert rst at clear cycle 10 -> all registers 0, clrBusy 0 immediately and remaining 0 after release.

Source files
------------

// File: rtl/reg_file_pkg.sv
// ============================================================================
// Module   : reg_file_pkg
// Purpose  : Shared types and constants for the multi-port register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_file_pkg;

  // Number of write ports on the register file.
  localparam int NumWritePorts = 2;

  // Sequential-clear controller states.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
// Module   : reg_scoreboard
// Purpose  : Busy-bit vector, one bit per register. A single set port marks a
//            register as waiting for a result; several clear ports release it.
//            The set port takes priority over any clear to the same index.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_scoreboard #(
  parameter int NumRegs    = 32,
  parameter int IndexWidth = $clog2(NumRegs),
  parameter int NumClr     = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              setEn_i,
  input  logic [IndexWidth-1:0]             setAddr_i,
  input  logic [NumClr-1:0]                 clrEn_i,
  input  logic [NumClr-1:0][IndexWidth-1:0] clrAddr_i,
  output logic [NumRegs-1:0]                busy_o
);

  logic [NumRegs-1:0] busy_q;
  logic [NumRegs-1:0] busy_d;

  // Next busy vector: apply all clears, then the set so it wins on collision.
  always_comb begin
    busy_d = busy_q;
    for (int c = 0; c < NumClr; c++) begin
      if (clrEn_i[c]) begin
        busy_d[clrAddr_i[c]] = 1'b0;
      end
    end
    if (setEn_i) begin
      busy_d[setAddr_i] = 1'b1;
    end
  end

  // Busy vector register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

`default_nettype wire

// File: rtl/reg_file_mp.sv
// ============================================================================
// Module   : reg_file_mp
// Purpose  : Two-write / N-read register file with a busy-bit scoreboard and
//            a sequential clear engine (one register per cycle). Register 0
//            is hard-wired to zero.
// Options  : REG_FILE_BYPASS_EN - forward same-cycle write data (port 1 first)
//            to the read ports and hide the busy bit of a written register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DataWidth    = 64,
  parameter int NumRegs      = 32,
  parameter int NumReadPorts = 3,
  parameter int IndexWidth   = $clog2(NumRegs)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NumWritePorts-1:0]               writeEn,
  input  logic [NumWritePorts-1:0][IndexWidth-1:0] writeAddr,
  input  logic [NumWritePorts-1:0][DataWidth-1:0]  writeData,
  input  logic [NumReadPorts-1:0][IndexWidth-1:0]  readAddr,
  output logic [NumReadPorts-1:0][DataWidth-1:0]   readData,
  output logic [NumReadPorts-1:0]                readBusy,
  input  logic                                   rsvEn,
  input  logic [IndexWidth-1:0]                  rsvAddr,
  input  logic                                   clrStart,
  output logic                                   clrBusy
);

  localparam logic [IndexWidth-1:0] LastIdx = IndexWidth'(NumRegs - 1);

  logic [DataWidth-1:0]     regs_q [NumRegs];
  clr_state_e               clr_state_q;
  logic [IndexWidth-1:0]    clr_cnt_q;
  logic [NumWritePorts-1:0] w_wr_en;
  logic                     w_rsv_en;
  logic [NumRegs-1:0]       w_busy;

  assign clrBusy = (clr_state_q == ST_CLEAR);

  // Commands are dropped during a clear and never touch register 0.
  for (genvar p = 0; p < NumWritePorts; p++) begin : g_wr_en
    assign w_wr_en[p] = writeEn[p] && !clrBusy && (writeAddr[p] != '0);
  end
  assign w_rsv_en = rsvEn && !clrBusy && (rsvAddr != '0);

  // Register storage: clear engine wipes one entry per cycle, otherwise the
  // write ports update in ascending order so port 1 wins a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (clrBusy) begin
      regs_q[clr_cnt_q] <= '0;
    end else begin
      for (int p = 0; p < NumWritePorts; p++) begin
        if (w_wr_en[p]) begin
          regs_q[writeAddr[p]] <= writeData[p];
        end
      end
    end
  end

  // Clear controller: walks indices 1..NumRegs-1 then returns to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_state_q <= ST_IDLE;
      clr_cnt_q   <= '0;
    end else begin
      case (clr_state_q)
        ST_IDLE: begin
          if (clrStart) begin
            clr_state_q <= ST_CLEAR;
            clr_cnt_q   <= IndexWidth'(1);
          end
        end
        ST_CLEAR: begin
          if (clr_cnt_q == LastIdx) begin
            clr_state_q <= ST_IDLE;
            clr_cnt_q   <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_q + IndexWidth'(1);
          end
        end
        default: begin
          clr_state_q <= ST_IDLE;
          clr_cnt_q   <= '0;
        end
      endcase
    end
  end

  // Busy bits: write ports and the clear engine release, reservation sets.
  reg_scoreboard #(
    .NumRegs    (NumRegs),
    .IndexWidth (IndexWidth),
    .NumClr     (NumWritePorts + 1)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .setEn_i   (w_rsv_en),
    .setAddr_i (rsvAddr),
    .clrEn_i   ({clrBusy, w_wr_en}),
    .clrAddr_i ({clr_cnt_q, writeAddr}),
    .busy_o    (w_busy)
  );

  function automatic logic [DataWidth-1:0] read_data(input logic [IndexWidth-1:0] a);
    logic [DataWidth-1:0] v;
    v = (a == '0) ? '0 : regs_q[a];
`ifdef REG_FILE_BYPASS_EN
    for (int p = 0; p < NumWritePorts; p++) begin
      if (w_wr_en[p] && (writeAddr[p] == a)) begin
        v = writeData[p];
      end
    end
`endif
    return v;
  endfunction

  function automatic logic read_busy(input logic [IndexWidth-1:0] a);
    logic b;
    b = w_busy[a];
`ifdef REG_FILE_BYPASS_EN
    for (int p = 0; p < NumWritePorts; p++) begin
      if (w_wr_en[p] && (writeAddr[p] == a) && !(w_rsv_en && (rsvAddr == a))) begin
        b = 1'b0;
      end
    end
`endif
    return b;
  endfunction

  for (genvar r = 0; r < NumReadPorts; r++) begin : g_read
    assign readData[r] = read_data(readAddr[r]);
    assign readBusy[r] = read_busy(readAddr[r]);
  end

endmodule

`default_nettype wire
